// File: rtl/input_debounce_pair.sv
// input_debounce_pair: two-channel synchroniser and debouncer with registered level, edge and combined-rise outputs
module input_debounce_pair #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic a1,
  output logic a2,
  output logic a1_rise,
  output logic a1_fall,
  output logic a2_rise,
  output logic a2_fall,
  output logic both_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync [2];
  logic [CW-1:0] cnt [2];
  logic [1:0] raw, s, stable, nxt, done, rise, fall;
  logic both;
  // next stable level: accept s once it has differed for the full count
  always_comb begin
    raw = {btn2_raw, btn1_raw};
    s = '0;
    done = '0;
    nxt = '0;
    for (int i = 0; i < 2; i++) begin
      s[i] = sync[i][SYNC_STAGES-1];
      done[i] = (s[i] != stable[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      nxt[i] = done[i] ? s[i] : stable[i];
    end
  end
  // synchroniser chains, debounce counters, levels and pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= '0;
        cnt[i] <= '0;
      end
      stable <= '0;
      rise <= '0;
      fall <= '0;
      both <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
        cnt[i] <= (s[i] == stable[i] || done[i]) ? '0 : cnt[i] + CW'(1);
      end
      stable <= nxt;
      rise <= nxt & ~stable;
      fall <= ~nxt & stable;
      both <= (&nxt) & ~(&stable);
    end
  end
  assign a1 = stable[0];
  assign a2 = stable[1];
  assign a1_rise = rise[0];
  assign a1_fall = fall[0];
  assign a2_rise = rise[1];
  assign a2_fall = fall[1];
  assign both_rise = both;
endmodule

// File: tb/tb_input_debounce_pair.sv
// tb_input_debounce_pair: directed scenarios checked each cycle against a run-length model of the debouncer
module tb_input_debounce_pair;
  localparam int DC = 4;
  localparam int SS = 2;
  logic clk = 1'b0, reset = 1'b1, btn1_raw = 1'b0, btn2_raw = 1'b0;
  logic a1, a2, a1_rise, a1_fall, a2_rise, a2_fall, both_rise;
  int vectors = 0, miscompares = 0;
  int hist [2][SS];
  int run [2];
  int m_a [2], m_r [2], m_f [2];
  int m_both;
  int n_a1r, n_a1f, n_a2r, n_a2f, n_both, n_a1hi, n_a2hi, n_all3, n_both_a1r, n_both_a2r, first_a1r, stepno;

  input_debounce_pair #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .btn1_raw(btn1_raw), .btn2_raw(btn2_raw),
    .a1(a1), .a2(a2), .a1_rise(a1_rise), .a1_fall(a1_fall),
    .a2_rise(a2_rise), .a2_fall(a2_fall), .both_rise(both_rise)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_tally();
    n_a1r = 0; n_a1f = 0; n_a2r = 0; n_a2f = 0; n_both = 0; n_a1hi = 0; n_a2hi = 0;
    n_all3 = 0; n_both_a1r = 0; n_both_a2r = 0; first_a1r = 0; stepno = 0;
  endtask

  // one clock edge: advance model with the sampled inputs, then compare every output
  task automatic step();
    int raw [2];
    int sv, old_and;
    raw[0] = int'(btn1_raw);
    raw[1] = int'(btn2_raw);
    @(posedge clk);
    old_and = m_a[0] & m_a[1];
    for (int c = 0; c < 2; c++) begin
      m_r[c] = 0;
      m_f[c] = 0;
      if (reset) begin
        for (int k = 0; k < SS; k++) hist[c][k] = 0;
        run[c] = 0;
        m_a[c] = 0;
      end else begin
        sv = hist[c][SS-1];
        for (int k = SS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = raw[c];
        run[c] = (sv != m_a[c]) ? run[c] + 1 : 0;
        if (run[c] == DC) begin
          m_r[c] = sv;
          m_f[c] = 1 - sv;
          m_a[c] = sv;
          run[c] = 0;
        end
      end
    end
    m_both = reset ? 0 : ((m_a[0] & m_a[1]) & ~old_and);
    #1;
    check("a1", int'(a1), m_a[0]);
    check("a2", int'(a2), m_a[1]);
    check("a1_rise", int'(a1_rise), m_r[0]);
    check("a1_fall", int'(a1_fall), m_f[0]);
    check("a2_rise", int'(a2_rise), m_r[1]);
    check("a2_fall", int'(a2_fall), m_f[1]);
    check("both_rise", int'(both_rise), m_both);
    stepno++;
    n_a1r += int'(a1_rise); n_a1f += int'(a1_fall);
    n_a2r += int'(a2_rise); n_a2f += int'(a2_fall);
    n_both += int'(both_rise); n_a1hi += int'(a1); n_a2hi += int'(a2);
    n_all3 += int'(a1_rise & a2_rise & both_rise);
    n_both_a1r += int'(both_rise & a1_rise);
    n_both_a2r += int'(both_rise & a2_rise);
    if (a1_rise && first_a1r == 0) first_a1r = stepno;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < SS; k++) hist[c][k] = 0;
      run[c] = 0; m_a[c] = 0; m_r[c] = 0; m_f[c] = 0;
    end
    m_both = 0;
    clear_tally();
    reset = 1'b1;
    steps(3);
    check("reset_a1", int'(a1), 0);
    reset = 1'b0;
    // clean press on channel 1: rise expected at edge R+5, i.e. sixth step
    clear_tally();
    btn1_raw = 1'b1;
    steps(8);
    check("press_first_rise_step", first_a1r, 6);
    check("press_rise_count", n_a1r, 1);
    check("press_a1_high_cycles", n_a1hi, 3);
    check("press_a2_rise", n_a2r, 0);
    check("press_both", n_both, 0);
    btn1_raw = 1'b0;
    steps(10);
    // bounce: single-cycle toggles never reach the count
    clear_tally();
    for (int i = 0; i < 4; i++) begin
      btn1_raw = (i % 2 == 0);
      step();
    end
    btn1_raw = 1'b0;
    steps(20);
    check("bounce_a1_high", n_a1hi, 0);
    check("bounce_pulses", n_a1r + n_a1f, 0);
    // short glitch on channel 2, then a 4-cycle pulse that passes
    clear_tally();
    btn2_raw = 1'b1;
    steps(3);
    btn2_raw = 1'b0;
    steps(10);
    check("glitch_a2_high", n_a2hi, 0);
    clear_tally();
    btn2_raw = 1'b1;
    steps(4);
    btn2_raw = 1'b0;
    steps(12);
    check("pulse4_a2_high_cycles", n_a2hi, 4);
    check("pulse4_rise", n_a2r, 1);
    check("pulse4_fall", n_a2f, 1);
    // simultaneous press
    clear_tally();
    btn1_raw = 1'b1;
    btn2_raw = 1'b1;
    steps(8);
    check("combo_all3", n_all3, 1);
    check("combo_both_count", n_both, 1);
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    steps(10);
    // staggered press: both_rise coincides with a2_rise only
    clear_tally();
    btn1_raw = 1'b1;
    steps(10);
    btn2_raw = 1'b1;
    steps(10);
    check("stagger_both_count", n_both, 1);
    check("stagger_both_with_a2r", n_both_a2r, 1);
    check("stagger_both_with_a1r", n_both_a1r, 0);
    // release channel 1 then re-press
    clear_tally();
    btn1_raw = 1'b0;
    steps(8);
    check("release_a1_fall", n_a1f, 1);
    check("release_both", n_both, 0);
    clear_tally();
    btn1_raw = 1'b1;
    steps(8);
    check("repress_a1_rise", n_a1r, 1);
    check("repress_both", n_both, 1);
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    steps(10);
    // reset mid-count
    clear_tally();
    btn1_raw = 1'b1;
    steps(3);
    reset = 1'b1;
    step();
    check("midreset_a1", int'(a1), 0);
    check("midreset_rise", int'(a1_rise), 0);
    reset = 1'b0;
    clear_tally();
    steps(8);
    check("post_reset_first_rise_step", first_a1r, 6);
    check("post_reset_rise_count", n_a1r, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
